br_sync: RTL and testbench

- Parametrised, clocked successor to the combinational register file in the datapath.
- Two asynchronous read ports and one synchronous write port, with same-cycle write-to-read bypass.
- After reset, a clear sequencer zeroes every entry before accepting writes; `ready` tells the decode/execute stages when the file is usable.

---
 rtl/br_pkg.sv | 12 +
 rtl/br_clear_seq.sv | 51 +++++
 rtl/br_sync.sv | 73 +++++++
 tb/tb_br_sync.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and default widths for the br_sync register file.
package br_pkg;

  localparam int BR_DATA_W = 32;
  localparam int BR_ADDR_W = 5;

  typedef enum logic {CLEAR, RUN} br_state_t;

  typedef logic [BR_ADDR_W-1:0] br_addr_t;
  typedef logic [BR_DATA_W-1:0] br_data_t;

endpackage

// File: rtl/br_clear_seq.sv
// Post-reset clear sequencer: walks clr_addr over every entry, then raises ready.
module br_clear_seq
  import br_pkg::*;
#(
  parameter int ADDR_W = BR_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  br_state_t         state, state_nx;
  logic [ADDR_W-1:0] clr_cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= cnt_nx;
    end
  end

  // The edge that clears the last entry also hands over to RUN.
  always_comb begin
    state_nx = state;
    cnt_nx   = clr_cnt;
    case (state)
      CLEAR: begin
        if (clr_cnt == LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = clr_cnt + 1'b1;
        end
      end
      RUN: ;
    endcase
  end

  assign ready    = (state == RUN);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_cnt;

endmodule

// File: rtl/br_sync.sv
// Clocked register file: 2 async read ports, 1 sync write port, write-to-read bypass.
// Define BR_ZERO_REG_EN to hardwire entry 0 to zero.
module br_sync
  import br_pkg::*;
#(
  parameter int DATA_W = BR_DATA_W,
  parameter int ADDR_W = BR_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RR1,
  input  logic [ADDR_W-1:0] RR2,
  input  logic [ADDR_W-1:0] Writereg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              Regwrite,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              ready
);

  localparam logic [ADDR_W:0] NUM = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we, we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = ({1'b0, a} < NUM);
`ifdef BR_ZERO_REG_EN
    if (a == '0) ok = 1'b0;
`endif
    return ok;
  endfunction

  br_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A user write only lands in RUN, at a valid address, and never under reset.
  assign user_we = ready & ~rst & Regwrite & addr_ok(Writereg);
  assign we      = ~rst & (clr_we | user_we);
  assign waddr   = clr_we ? clr_addr : Writereg;
  assign wdata   = clr_we ? '0 : WriteData;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    RD1 = '0;
    if (ready && addr_ok(RR1))
      RD1 = (user_we && Writereg == RR1) ? WriteData : mem[RR1];
  end

  always_comb begin
    RD2 = '0;
    if (ready && addr_ok(RR2))
      RD2 = (user_we && Writereg == RR2) ? WriteData : mem[RR2];
  end

endmodule

// File: tb/tb_br_sync.sv
// Directed self-checking bench for br_sync (DATA_W=32, ADDR_W=5, DEPTH=32).
module tb_br_sync;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] RR1, RR2, Writereg;
  logic [DATA_W-1:0] WriteData;
  logic              Regwrite;
  logic [DATA_W-1:0] RD1, RD2;
  logic              ready;

  int tests;
  int fails;

  br_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RR1       (RR1),
    .RR2       (RR2),
    .Writereg  (Writereg),
    .WriteData (WriteData),
    .Regwrite  (Regwrite),
    .RD1       (RD1),
    .RD2       (RD2),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s: ready never rose, got %b want 1", name, ready);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    Regwrite = 1'b0;
    RR1 = '0;
    RR2 = '0;
    do_reset();
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got %b want 0", ready);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      RR1 = ADDR_W'(i - 1);
      RR2 = ADDR_W'(DEPTH - i);
      #1;
      tests++;
      if (RD1 !== '0 || RD2 !== '0) begin
        fails++;
        $display("FAIL clear_read_zero: RD1=%h RD2=%h want 0", RD1, RD2);
      end
      step();
      tests++;
      if (ready !== (i == DEPTH)) begin
        fails++;
        $display("FAIL clear_ready_cycle%0d: got %b want %b", i, ready, (i == DEPTH));
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      RR1 = ADDR_W'(i);
      RR2 = ADDR_W'(DEPTH - 1 - i);
      #1;
      tests++;
      if (RD1 !== '0 || RD2 !== '0) begin
        fails++;
        $display("FAIL idle_read_zero: addr %0d RD1=%h RD2=%h want 0", i, RD1, RD2);
      end
    end
  endtask

  task automatic test_write_during_clear();
    do_reset();
    step();
    step();
    Regwrite  = 1'b1;
    Writereg  = 5'd7;
    WriteData = 32'hDEADBEEF;
    RR1       = 5'd7;
    #1;
    tests++;
    if (RD1 !== '0) begin
      fails++;
      $display("FAIL clear_no_bypass: got %h want 0", RD1);
    end
    for (int i = 0; i < 10; i++) step();
    Regwrite = 1'b0;
    wait_ready("write_during_clear");
    #1;
    tests++;
    if (RD1 !== '0) begin
      fails++;
      $display("FAIL write_during_clear: got %h want 0", RD1);
    end
  endtask

  task automatic test_write_read();
    Regwrite  = 1'b1;
    Writereg  = 5'd5;
    WriteData = 32'h12345678;
    step();
    Regwrite = 1'b0;
    RR1 = 5'd5;
    RR2 = 5'd6;
    #1;
    tests++;
    if (RD1 !== 32'h12345678) begin
      fails++;
      $display("FAIL write_read_rd1: got %h want 12345678", RD1);
    end
    tests++;
    if (RD2 !== '0) begin
      fails++;
      $display("FAIL write_read_rd2: got %h want 0", RD2);
    end
  endtask

  task automatic test_bypass();
    Regwrite  = 1'b1;
    Writereg  = 5'd9;
    WriteData = 32'hA5A5A5A5;
    RR1 = 5'd9;
    RR2 = 5'd9;
    #1;
    tests++;
    if (RD1 !== 32'hA5A5A5A5 || RD2 !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL bypass_same_cycle: RD1=%h RD2=%h want a5a5a5a5", RD1, RD2);
    end
    step();
    Regwrite  = 1'b0;
    WriteData = 32'h0;
    #1;
    tests++;
    if (RD1 !== 32'hA5A5A5A5 || RD2 !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL bypass_persist: RD1=%h RD2=%h want a5a5a5a5", RD1, RD2);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 32'h0000_1111;
    vals[1] = 32'h2222_0000;
    vals[2] = 32'hCAFE_F00D;
    Regwrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Writereg  = ADDR_W'(10 + i);
      WriteData = vals[i];
      step();
    end
    Writereg  = 5'd31;
    WriteData = 32'h1;
    step();
    WriteData = 32'h8000_0002;
    step();
    Regwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      RR1 = ADDR_W'(10 + i);
      RR2 = ADDR_W'(12 - i);
      #1;
      tests++;
      if (RD1 !== vals[i] || RD2 !== vals[2 - i]) begin
        fails++;
        $display("FAIL back_to_back_%0d: RD1=%h RD2=%h want %h %h", i, RD1, RD2, vals[i], vals[2 - i]);
      end
    end
    RR1 = 5'd31;
    #1;
    tests++;
    if (RD1 !== 32'h8000_0002) begin
      fails++;
      $display("FAIL last_write_wins: got %h want 80000002", RD1);
    end
  endtask

  task automatic test_reset_run();
    int n;
    Regwrite  = 1'b1;
    Writereg  = 5'd3;
    WriteData = 32'h55;
    step();
    Regwrite = 1'b0;
    RR1 = 5'd3;
    #1;
    tests++;
    if (RD1 !== 32'h55) begin
      fails++;
      $display("FAIL reset_run_pre: got %h want 55", RD1);
    end
    rst       = 1'b1;
    Regwrite  = 1'b1;
    Writereg  = 5'd4;
    WriteData = 32'h77;
    step();
    rst      = 1'b0;
    Regwrite = 1'b0;
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_run_ready_drop: got %b want 0", ready);
    end
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    tests++;
    if (n != DEPTH) begin
      fails++;
      $display("FAIL reset_run_clear_len: got %0d cycles want %0d", n, DEPTH);
    end
    RR1 = 5'd3;
    RR2 = 5'd4;
    #1;
    tests++;
    if (RD1 !== '0 || RD2 !== '0) begin
      fails++;
      $display("FAIL reset_run_cleared: RD1=%h RD2=%h want 0", RD1, RD2);
    end
  endtask

  task automatic test_zero_reg();
    logic [DATA_W-1:0] exp;
`ifdef BR_ZERO_REG_EN
    exp = '0;
`else
    exp = 32'hFFFFFFFF;
`endif
    Regwrite  = 1'b1;
    Writereg  = 5'd0;
    WriteData = 32'hFFFFFFFF;
    RR1 = 5'd0;
    #1;
    tests++;
    if (RD1 !== exp) begin
      fails++;
      $display("FAIL zero_reg_bypass: got %h want %h", RD1, exp);
    end
    step();
    Regwrite  = 1'b0;
    WriteData = '0;
    #1;
    tests++;
    if (RD1 !== exp) begin
      fails++;
      $display("FAIL zero_reg_stored: got %h want %h", RD1, exp);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    Regwrite  = 1'b0;
    Writereg  = '0;
    WriteData = '0;
    RR1       = '0;
    RR2       = '0;
    test_reset();
    test_write_during_clear();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_reset_run();
    test_zero_reg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
